// File: rtl/mprj_pkg.sv
// mprj_pkg -- shared types and constants for the shared-port bus arbiter.
//   state_e       : arbiter FSM states
//   GNT_*         : gnt_o encodings (01 WB, 10 LA, 00 none)
//   TIMEOUT_DATA  : read data returned when the device never acks
//   rr_pick       : round-robin choice between the two requesters
package mprj_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_WB = 2'd1,
        ST_BUSY_LA = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [1:0]  GNT_NONE     = 2'b00;
    localparam logic [1:0]  GNT_WB       = 2'b01;
    localparam logic [1:0]  GNT_LA       = 2'b10;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    // With both requesters pending, the one not granted last wins.
    function automatic logic [1:0] rr_pick(input logic wb_pend,
                                           input logic la_pend,
                                           input logic last_la);
        logic [1:0] pick;
        pick = GNT_NONE;
        if (wb_pend && la_pend) pick = last_la ? GNT_WB : GNT_LA;
        else if (wb_pend)       pick = GNT_WB;
        else if (la_pend)       pick = GNT_LA;
        return pick;
    endfunction

endpackage

// File: rtl/mprj_edge_det.sv
// mprj_edge_det -- rising-edge detector.
//   clk, rst_n : clock, async active-low reset (history cleared to 0)
//   d_i        : level input
//   rise_o     : high in the cycle d_i is 1 and was 0 at the previous edge
module mprj_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/mprj_bus_arbiter.sv
// mprj_bus_arbiter -- arbitrates a Wishbone slave port and a logic-analyzer
// request port onto one shared device port, with round-robin arbitration
// and a per-access timeout.
//   wb_clk_i / wb_rst_n_i : clock, async active-low reset
//   wbs_*                 : Wishbone slave (decode window at BASE_ADDR)
//   la_*                  : LA port; a rising edge on la_req_i starts one access
//   dev_*                 : shared device port, dev_req_o held until ack/timeout
//   gnt_o                 : current owner (01 WB, 10 LA, 00 none)
//   timeout_o             : one-cycle pulse when an access times out
module mprj_bus_arbiter
    import mprj_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic              la_req_i,
    input  logic              la_we_i,
    input  logic [ADDR_W-1:0] la_adr_i,
    input  logic [31:0]       la_dat_i,
    output logic [31:0]       la_dat_o,
    output logic              la_done_o,
    output logic              dev_req_o,
    output logic              dev_we_o,
    output logic [3:0]        dev_sel_o,
    output logic [ADDR_W-1:0] dev_adr_o,
    output logic [31:0]       dev_wdat_o,
    input  logic [31:0]       dev_rdat_i,
    input  logic              dev_ack_i,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);

    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // byte-lane bits of the WB address carry no information for word access
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    logic wb_in_win, wb_hit, wb_miss, la_rise;
    logic [31:0] resp_dat;
    logic [1:0]  pick;

    assign wb_in_win = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
    assign wb_hit    = wbs_cyc_i & wbs_stb_i &  wb_in_win;
    assign wb_miss   = wbs_cyc_i & wbs_stb_i & ~wb_in_win;
    assign resp_dat  = dev_ack_i ? dev_rdat_i : TIMEOUT_DATA;

    mprj_edge_det u_la_edge (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_n_i),
        .d_i    (la_req_i),
        .rise_o (la_rise)
    );

    state_e              state_q,    state_d;
    logic                la_pend_q,  la_pend_d;
    logic                la_we_q,    la_we_d;
    logic [ADDR_W-1:0]   la_adr_q,   la_adr_d;
    logic [31:0]         la_wdat_q,  la_wdat_d;
    logic                last_la_q,  last_la_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                abort_q,    abort_d;
    logic                dev_req_q,  dev_req_d;
    logic                dev_we_q,   dev_we_d;
    logic [3:0]          dev_sel_q,  dev_sel_d;
    logic [ADDR_W-1:0]   dev_adr_q,  dev_adr_d;
    logic [31:0]         dev_wdat_q, dev_wdat_d;
    logic [1:0]          gnt_q,      gnt_d;
    logic                wbs_ack_q,  wbs_ack_d;
    logic [31:0]         wbs_dat_q,  wbs_dat_d;
    logic                la_done_q,  la_done_d;
    logic [31:0]         la_dat_q,   la_dat_d;
    logic                timeout_q,  timeout_d;

    assign pick = rr_pick(wb_hit, la_pend_q, last_la_q);

    always_comb begin
        state_d    = state_q;
        la_pend_d  = la_pend_q;
        la_we_d    = la_we_q;
        la_adr_d   = la_adr_q;
        la_wdat_d  = la_wdat_q;
        last_la_d  = last_la_q;
        cnt_d      = cnt_q;
        abort_d    = abort_q;
        dev_req_d  = dev_req_q;
        dev_we_d   = dev_we_q;
        dev_sel_d  = dev_sel_q;
        dev_adr_d  = dev_adr_q;
        dev_wdat_d = dev_wdat_q;
        gnt_d      = gnt_q;
        la_dat_d   = la_dat_q;
        // pulse outputs default low; wbs_dat_o is zero whenever ack is low
        wbs_ack_d  = 1'b0;
        wbs_dat_d  = 32'h0;
        la_done_d  = 1'b0;
        timeout_d  = 1'b0;

        // edges arriving while an LA access is outstanding are dropped
        if (la_rise && !la_pend_q) begin
            la_pend_d = 1'b1;
            la_we_d   = la_we_i;
            la_adr_d  = la_adr_i;
            la_wdat_d = la_dat_i;
        end

        // out-of-window cycles get an empty ack; the ack_q term keeps a
        // master still holding stb in the ack cycle from being acked twice
        if (wb_miss && !wbs_ack_q) wbs_ack_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick == GNT_WB) begin
                    state_d    = ST_BUSY_WB;
                    last_la_d  = 1'b0;
                    abort_d    = 1'b0;
                    dev_req_d  = 1'b1;
                    dev_we_d   = wbs_we_i;
                    dev_sel_d  = wbs_sel_i;
                    dev_adr_d  = wbs_adr_i[ADDR_W+1:2];
                    dev_wdat_d = wbs_dat_i;
                    gnt_d      = GNT_WB;
                end else if (pick == GNT_LA) begin
                    state_d    = ST_BUSY_LA;
                    last_la_d  = 1'b1;
                    dev_req_d  = 1'b1;
                    dev_we_d   = la_we_q;
                    dev_sel_d  = 4'hF;
                    dev_adr_d  = la_adr_q;
                    dev_wdat_d = la_wdat_q;
                    gnt_d      = GNT_LA;
                end
            end
            ST_BUSY_WB, ST_BUSY_LA: begin
                // a WB abort lets the device access finish but kills the ack
                if (state_q == ST_BUSY_WB && !wbs_cyc_i) abort_d = 1'b1;
                if (dev_ack_i || cnt_q == CNT_LAST) begin
                    state_d   = ST_RESP;
                    dev_req_d = 1'b0;
                    gnt_d     = GNT_NONE;
                    cnt_d     = '0;
                    timeout_d = ~dev_ack_i;
                    if (state_q == ST_BUSY_WB) begin
                        if (!abort_q && wbs_cyc_i) begin
                            wbs_ack_d = 1'b1;
                            wbs_dat_d = resp_dat;
                        end
                    end else begin
                        la_done_d = 1'b1;
                        la_dat_d  = resp_dat;
                        la_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= ST_IDLE;
            la_pend_q  <= 1'b0;
            la_we_q    <= 1'b0;
            la_adr_q   <= '0;
            la_wdat_q  <= 32'h0;
            last_la_q  <= 1'b1;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            dev_req_q  <= 1'b0;
            dev_we_q   <= 1'b0;
            dev_sel_q  <= 4'h0;
            dev_adr_q  <= '0;
            dev_wdat_q <= 32'h0;
            gnt_q      <= GNT_NONE;
            wbs_ack_q  <= 1'b0;
            wbs_dat_q  <= 32'h0;
            la_done_q  <= 1'b0;
            la_dat_q   <= 32'h0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            la_pend_q  <= la_pend_d;
            la_we_q    <= la_we_d;
            la_adr_q   <= la_adr_d;
            la_wdat_q  <= la_wdat_d;
            last_la_q  <= last_la_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            dev_req_q  <= dev_req_d;
            dev_we_q   <= dev_we_d;
            dev_sel_q  <= dev_sel_d;
            dev_adr_q  <= dev_adr_d;
            dev_wdat_q <= dev_wdat_d;
            gnt_q      <= gnt_d;
            wbs_ack_q  <= wbs_ack_d;
            wbs_dat_q  <= wbs_dat_d;
            la_done_q  <= la_done_d;
            la_dat_q   <= la_dat_d;
            timeout_q  <= timeout_d;
        end
    end

    assign wbs_ack_o  = wbs_ack_q;
    assign wbs_dat_o  = wbs_dat_q;
    assign la_done_o  = la_done_q;
    assign la_dat_o   = la_dat_q;
    assign dev_req_o  = dev_req_q;
    assign dev_we_o   = dev_we_q;
    assign dev_sel_o  = dev_sel_q;
    assign dev_adr_o  = dev_adr_q;
    assign dev_wdat_o = dev_wdat_q;
    assign gnt_o      = gnt_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_mprj_bus_arbiter.sv
// Self-checking bench for mprj_bus_arbiter: directed scenarios followed by
// randomized WB/LA traffic checked against a transaction-level model.
module tb_mprj_bus_arbiter;

    localparam int AW  = 10;
    localparam int TMO = 16;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_n_i = 1'b0;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]    wbs_sel_i = 4'h0;
    logic [31:0]   wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
    logic [31:0]   wbs_dat_o;
    logic          wbs_ack_o;
    logic          la_req_i = 1'b0, la_we_i = 1'b0;
    logic [AW-1:0] la_adr_i = '0;
    logic [31:0]   la_dat_i = 32'h0;
    logic [31:0]   la_dat_o;
    logic          la_done_o;
    logic          dev_req_o, dev_we_o;
    logic [3:0]    dev_sel_o;
    logic [AW-1:0] dev_adr_o;
    logic [31:0]   dev_wdat_o;
    logic [31:0]   dev_rdat_i = 32'h0;
    logic          dev_ack_i = 1'b0;
    logic [1:0]    gnt_o;
    logic          timeout_o;

    mprj_bus_arbiter #(.ADDR_W(AW), .BASE_ADDR(32'h3000_0000), .TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .la_req_i(la_req_i), .la_we_i(la_we_i), .la_adr_i(la_adr_i),
        .la_dat_i(la_dat_i), .la_dat_o(la_dat_o), .la_done_o(la_done_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o), .dev_sel_o(dev_sel_o),
        .dev_adr_o(dev_adr_o), .dev_wdat_o(dev_wdat_o), .dev_rdat_i(dev_rdat_i),
        .dev_ack_i(dev_ack_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_vec = 0;
    int n_err = 0;
    bit last_wb = 1'b0;   // model: owner of the previous grant (reset: LA)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_start(input logic we, input logic [3:0] sel,
                            input logic [31:0] adr, input logic [31:0] dat);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
    endtask

    task automatic wb_stop();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    endtask

    task automatic la_start(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat);
        la_we_i = we; la_adr_i = adr; la_dat_i = dat; la_req_i = 1'b1;
        step();
        la_req_i = 1'b0;
    endtask

    // Plays the device for one granted access. lat = BUSY cycle (1-based) in
    // which dev_ack_i is raised; lat > TMO means the device never answers.
    task automatic serve(input logic [1:0] own, input int lat, input logic we,
                         input logic [3:0] sel, input logic [AW-1:0] adr,
                         input logic [31:0] wd);
        int w;
        logic [31:0] rd, exp_rd;
        rd = $urandom;
        w = 0;
        while (dev_req_o !== 1'b1 && w < 40) begin step(); w++; end
        chk("dev_req_rise", {31'h0, dev_req_o}, 32'h1);
        for (int k = 1; k <= TMO; k++) begin
            chk("busy_req",  {31'h0, dev_req_o}, 32'h1);
            chk("busy_gnt",  {30'h0, gnt_o}, {30'h0, own});
            chk("busy_adr",  {22'h0, dev_adr_o}, {22'h0, adr});
            chk("busy_sel",  {28'h0, dev_sel_o}, {28'h0, (own == 2'b10) ? 4'hF : sel});
            chk("busy_we",   {31'h0, dev_we_o}, {31'h0, we});
            chk("busy_wdat", dev_wdat_o, wd);
            chk("busy_ack",  {30'h0, wbs_ack_o, la_done_o}, 32'h0);
            if (k == lat) begin dev_ack_i = 1'b1; dev_rdat_i = rd; end
            step();
            dev_ack_i = 1'b0; dev_rdat_i = $urandom;
            if (k == lat) break;
        end
        exp_rd = (lat <= TMO) ? rd : 32'hDEAD_BEEF;
        chk("resp_req", {31'h0, dev_req_o}, 32'h0);
        chk("resp_tmo", {31'h0, timeout_o}, {31'h0, (lat > TMO)});
        if (own == 2'b01) begin
            chk("resp_wbs_ack", {31'h0, wbs_ack_o}, 32'h1);
            chk("resp_wbs_dat", wbs_dat_o, exp_rd);
            chk("resp_la_done", {31'h0, la_done_o}, 32'h0);
            wb_stop();
        end else begin
            chk("resp_la_done", {31'h0, la_done_o}, 32'h1);
            chk("resp_la_dat",  la_dat_o, exp_rd);
            chk("resp_wbs_ack", {31'h0, wbs_ack_o}, 32'h0);
        end
        step();
        chk("idle_pulses", {29'h0, wbs_ack_o, la_done_o, timeout_o}, 32'h0);
        chk("idle_wbs_dat", wbs_dat_o, 32'h0);
        if (own == 2'b10) chk("idle_la_hold", la_dat_o, exp_rd);
        last_wb = (own == 2'b01);
    endtask

    initial begin
        int pat, l1, l2, cnt_done, cnt_req;
        logic we_w, we_l;
        logic [3:0] sel_w;
        logic [AW-1:0] wrd_w, adr_l;
        logic [1:0] off;
        logic [31:0] dat_w, dat_l;
        logic [1:0] first;

        // reset state while held in reset
        #2;
        chk("rst_outs", {wbs_ack_o, la_done_o, dev_req_o, dev_we_o, timeout_o, gnt_o, dev_sel_o}, 32'h0);
        chk("rst_data", wbs_dat_o | la_dat_o | dev_wdat_o | {22'h0, dev_adr_o}, 32'h0);
        step();
        wb_rst_n_i = 1'b1;
        step();

        // both pending after reset: WB first, one idle cycle, then LA
        la_start(1'b1, 10'h2A5, 32'hA5A5_0001);
        chk("both_idle", {31'h0, dev_req_o}, 32'h0);
        wb_start(1'b1, 4'h3, 32'h3000_0044, 32'h1234_5678);
        serve(2'b01, 2, 1'b1, 4'h3, 10'd17, 32'h1234_5678);
        chk("gap_req", {29'h0, dev_req_o, gnt_o}, 32'h0);
        serve(2'b10, 1, 1'b1, 4'hF, 10'h2A5, 32'hA5A5_0001);

        // WB write to 0x3000_0010, ack two cycles after dev_req_o
        wb_start(1'b1, 4'hF, 32'h3000_0010, 32'hCAFE_0010);
        serve(2'b01, 3, 1'b1, 4'hF, 10'd4, 32'hCAFE_0010);

        // WB read outside the window
        wb_start(1'b0, 4'hF, 32'h2000_0000, 32'h0);
        step();
        chk("miss_ack", {31'h0, wbs_ack_o}, 32'h1);
        chk("miss_dat", wbs_dat_o, 32'h0);
        chk("miss_req", {31'h0, dev_req_o}, 32'h0);
        step();
        wb_stop();
        chk("miss_ack2", {30'h0, wbs_ack_o, dev_req_o}, 32'h0);
        step();
        chk("miss_req2", {31'h0, dev_req_o}, 32'h0);

        // LA read, device silent -> timeout
        la_start(1'b0, 10'h155, 32'h0);
        serve(2'b10, TMO + 4, 1'b0, 4'hF, 10'h155, 32'h0);

        // second LA edge while pending is ignored
        la_start(1'b0, 10'h077, 32'h7777_0000);
        la_req_i = 1'b1;
        step();
        la_req_i = 1'b0;
        serve(2'b10, 3, 1'b0, 4'hF, 10'h077, 32'h7777_0000);
        cnt_done = 0; cnt_req = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_done += int'(la_done_o);
            cnt_req  += int'(dev_req_o);
        end
        chk("dup_edge_done", cnt_done, 0);
        chk("dup_edge_req",  cnt_req, 0);

        // WB abort: access completes, no ack
        wb_start(1'b0, 4'hF, 32'h3000_0100, 32'h0);
        step();
        chk("abort_req", {31'h0, dev_req_o}, 32'h1);
        wb_stop();
        dev_ack_i = 1'b1;
        step();
        dev_ack_i = 1'b0;
        chk("abort_resp", {30'h0, dev_req_o, wbs_ack_o}, 32'h0);
        step();
        chk("abort_idle", {30'h0, dev_req_o, wbs_ack_o}, 32'h0);
        last_wb = 1'b1;

        // stray dev_ack_i while idle
        dev_ack_i = 1'b1;
        step();
        dev_ack_i = 1'b0;
        chk("stray_ack", {28'h0, dev_req_o, wbs_ack_o, la_done_o, timeout_o}, 32'h0);
        step();
        chk("stray_ack2", {28'h0, dev_req_o, wbs_ack_o, la_done_o, timeout_o}, 32'h0);

        // randomized traffic against the transaction model
        for (int i = 0; i < 14; i++) begin
            pat   = $urandom_range(0, 2);
            l1    = $urandom_range(1, TMO + 2);
            l2    = $urandom_range(1, TMO + 2);
            we_w  = 1'($urandom);  sel_w = 4'($urandom);
            wrd_w = AW'($urandom); off   = 2'($urandom);
            dat_w = $urandom;
            we_l  = 1'($urandom);  adr_l = AW'($urandom);
            dat_l = $urandom;
            if (pat == 0) begin
                wb_start(we_w, sel_w, {20'h30000, wrd_w, off}, dat_w);
                serve(2'b01, l1, we_w, sel_w, wrd_w, dat_w);
            end else if (pat == 1) begin
                la_start(we_l, adr_l, dat_l);
                serve(2'b10, l1, we_l, 4'hF, adr_l, dat_l);
            end else begin
                la_start(we_l, adr_l, dat_l);
                wb_start(we_w, sel_w, {20'h30000, wrd_w, off}, dat_w);
                first = last_wb ? 2'b10 : 2'b01;
                if (first == 2'b01) serve(2'b01, l1, we_w, sel_w, wrd_w, dat_w);
                else                serve(2'b10, l1, we_l, 4'hF, adr_l, dat_l);
                chk("rr_gap", {29'h0, dev_req_o, gnt_o}, 32'h0);
                if (first == 2'b01) serve(2'b10, l2, we_l, 4'hF, adr_l, dat_l);
                else                serve(2'b01, l2, we_w, sel_w, wrd_w, dat_w);
            end
            step();
        end

        // reset in the middle of an LA access
        la_start(1'b1, 10'h3C3, 32'h5555_AAAA);
        step();
        step();
        chk("pre_rst_req", {31'h0, dev_req_o}, 32'h1);
        wb_rst_n_i = 1'b0;
        #1;
        chk("rst_req_now", {29'h0, dev_req_o, gnt_o}, 32'h0);
        chk("rst_la_dat", la_dat_o, 32'h0);
        step();
        wb_rst_n_i = 1'b1;
        last_wb = 1'b0;
        cnt_done = 0; cnt_req = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cnt_done += int'(la_done_o | wbs_ack_o);
            cnt_req  += int'(dev_req_o);
        end
        chk("post_rst_done", cnt_done, 0);
        chk("post_rst_req",  cnt_req, 0);
        wb_start(1'b0, 4'h5, 32'h3000_0FFC, 32'h0);
        serve(2'b01, 2, 1'b0, 4'h5, 10'h3FF, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
